// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, transmitter state encoding and parity helper.
// Imported by both the transmitter side and the matching receiver.
package uart_pkg;

    localparam int DATA_W       = 7;
    localparam int FRAME_BITS   = 10;
    localparam int CLKS_PER_BIT = 1736;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_tx_state_t;

    // Even parity: returned bit makes the total number of ones even.
    function automatic logic even_parity(input logic [DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Frame sequencer: start bit, data bits LSB-first, even parity, stop bit.
// The data word must stay stable from the load pulse until the frame ends.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    output logic              tx_line,
    output logic              busy,
    output logic              last_cycle
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       BIT_LAST = 3'(DATA_W - 1);

    uart_tx_state_t   state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic             tx_q;
    logic             busy_q;
    logic             baud_tc;

    assign baud_tc    = (cnt_q == CNT_LAST);
    // Lets the arbiter line up the next accept with the return to idle.
    assign last_cycle = (state_q == ST_STOP) && baud_tc;
    assign tx_line    = tx_q;
    assign busy       = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            if (state_q != ST_IDLE) begin
                cnt_q <= baud_tc ? '0 : cnt_q + 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        state_q <= ST_START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_tc) begin
                        state_q <= ST_DATA;
                        bit_q   <= '0;
                        tx_q    <= data[0];
                    end
                end
                ST_DATA: begin
                    if (baud_tc) begin
                        if (bit_q == BIT_LAST) begin
                            state_q <= ST_PARITY;
                            tx_q    <= even_parity(data);
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= data[bit_q + 3'd1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (baud_tc) begin
                        state_q <= ST_STOP;
                        tx_q    <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_tc) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmit line between NUM_REQ requesters.
// Selects, latches the granted word and pulses req_ready; the serializer sends the frame.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = uart_pkg::DATA_W,
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        tx_line,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

    localparam int              ID_W    = $clog2(NUM_REQ);
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(NUM_REQ - 1);

    logic [DATA_W-1:0]  req_word [NUM_REQ];
    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [DATA_W-1:0]  word_q, word_d;
    logic               sel_found;
    logic [ID_W-1:0]    sel_idx;
    logic               ser_busy;
    logic               ser_last;
    logic               can_accept;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_word
            assign req_word[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Accepting during the final stop cycle gives the 10*CLKS_PER_BIT+1 back-to-back period.
    assign can_accept = (!ser_busy || ser_last) && (ready_q == '0);

    // Scan downward in distance so the nearest valid index after last_q wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_valid[(int'(last_q) + k) % NUM_REQ]) begin
                sel_found = 1'b1;
                sel_idx   = ID_W'((int'(last_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        ready_d = '0;
        grant_d = grant_q;
        last_d  = last_q;
        word_d  = word_q;
        if (can_accept && sel_found) begin
            ready_d[sel_idx] = 1'b1;
            grant_d          = sel_idx;
            last_d           = sel_idx;
            word_d           = req_word[sel_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= '0;
            grant_q <= '0;
            last_q  <= ID_LAST;
            word_q  <= '0;
        end else begin
            ready_q <= ready_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            word_q  <= word_d;
        end
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_serializer (
        .clk        (clk),
        .rst        (rst),
        .load       (|ready_q),
        .data       (word_q),
        .tx_line    (tx_line),
        .busy       (ser_busy),
        .last_cycle (ser_last)
    );

    assign req_ready = ready_q;
    assign busy      = ser_busy;
    assign grant_id  = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with NUM_REQ=4, CLKS_PER_BIT=4.
// Frame table plus hand sequences for arbitration order, back-to-back timing and mid-frame reset.
module tb_uart_tx_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 7;
    localparam int CPB = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              tx_line;
    logic              busy;
    logic [1:0]        grant_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (NR),
        .DATA_W       (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_line   (tx_line),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    // bits[9:0] = stop, parity, d6..d0, start (bits[k] is the k-th level on the line)
    typedef struct {
        int         id;
        logic [6:0] data;
        logic [9:0] bits;
    } frame_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Waits at negedges for an accept pulse; an expired bound counts as a failed check.
    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_frame(input frame_vec_t v);
        bit ok;
        req_data[v.id*DW +: DW] = v.data;
        req_valid[v.id] = 1'b1;
        wait_accept(ok);
        if (ok) begin
            chk("frame_ready", req_ready, 32'(1 << v.id));
            chk("frame_grant", grant_id, v.id);
            chk("frame_accept_busy", busy, 0);
            chk("frame_accept_tx", tx_line, 1);
            req_valid[v.id] = 1'b0;
            for (int c = 0; c < 10*CPB; c++) begin
                @(negedge clk);
                chk("frame_tx", tx_line, v.bits[c/CPB]);
                chk("frame_busy", busy, 1);
                chk("frame_no_ready", req_ready, 0);
            end
            @(negedge clk);
            chk("frame_end_busy", busy, 0);
            chk("frame_end_tx", tx_line, 1);
            $display("frame req=%0d data=%02h grant=%0d", v.id, v.data, grant_id);
        end
    endtask

    frame_vec_t vecs [5];
    int exp_fair [4];
    int n_acc, idle_cnt, last_c;
    bit ok;

    initial begin
        vecs[0] = '{id: 0, data: 7'h55, bits: 10'b1_0_1010101_0};
        vecs[1] = '{id: 2, data: 7'h07, bits: 10'b1_1_0000111_0};
        vecs[2] = '{id: 1, data: 7'h7F, bits: 10'b1_1_1111111_0};
        vecs[3] = '{id: 0, data: 7'h40, bits: 10'b1_1_1000000_0};
        vecs[4] = '{id: 3, data: 7'h00, bits: 10'b1_0_0000000_0};
        exp_fair = '{1, 2, 1, 2};

        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;

        // Reset held with random requests
        for (int i = 0; i < 3; i++) begin
            req_valid = 4'($urandom);
            @(negedge clk);
            chk("rst_tx", tx_line, 1);
            chk("rst_busy", busy, 0);
            chk("rst_ready", req_ready, 0);
            chk("rst_grant", grant_id, 0);
        end
        rst       = 1'b0;
        req_valid = '0;
        @(negedge clk);
        chk("post_rst_tx", tx_line, 1);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_ready", req_ready, 0);
        chk("post_rst_grant", grant_id, 0);
        $display("reset done");

        for (int i = 0; i < 5; i++) run_frame(vecs[i]);

        // All requesters at once, held: order 0..3, 41-cycle period, one gap each
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 7'(8'h11 * (i + 1));
        req_valid = 4'hF;
        n_acc = 0;
        idle_cnt = 0;
        last_c = 0;
        for (int c = 0; c < 250 && n_acc < 4; c++) begin
            @(negedge clk);
            if (n_acc > 0 && !busy) begin
                idle_cnt++;
                chk("allreq_gap_tx", tx_line, 1);
            end
            if (req_ready != '0) begin
                chk("allreq_ready", req_ready, 32'(1 << n_acc));
                chk("allreq_grant", grant_id, n_acc);
                if (n_acc > 0) chk("allreq_period", c - last_c, 41);
                $display("allreq grant=%0d cycle=%0d", grant_id, c);
                last_c = c;
                n_acc++;
            end
        end
        req_valid = '0;
        chk("allreq_count", n_acc, 4);
        chk("allreq_gap_cycles", idle_cnt, 3);
        repeat (10*CPB + 2) @(negedge clk);

        // Fairness: 1 held, 2 raised during the first frame
        req_valid = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            wait_accept(ok);
            if (ok) begin
                chk("fair_grant", grant_id, exp_fair[i]);
                chk("fair_ready", req_ready, 32'(1 << exp_fair[i]));
                $display("fair grant=%0d", grant_id);
            end
            if (i == 0) begin
                repeat (5) @(negedge clk);
                req_valid[2] = 1'b1;
            end
        end
        req_valid = '0;
        repeat (10*CPB + 2) @(negedge clk);

        // Reset at cycle 15 of a frame from requester 3
        req_data[3*DW +: DW] = 7'h2A;
        req_valid = 4'b1000;
        wait_accept(ok);
        if (ok) chk("midrst_grant3", grant_id, 3);
        req_valid = '0;
        repeat (15) @(negedge clk);
        chk("midrst_busy_before", busy, 1);
        rst       = 1'b1;
        req_valid = 4'hF;
        @(negedge clk);
        chk("midrst_tx", tx_line, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", req_ready, 0);
        chk("midrst_grant", grant_id, 0);
        rst = 1'b0;
        wait_accept(ok);
        if (ok) begin
            chk("midrst_first_grant", grant_id, 0);
            chk("midrst_first_ready", req_ready, 1);
            $display("post-reset grant=%0d", grant_id);
        end
        req_valid = '0;
        repeat (10*CPB + 2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART serial transmit line between `NUM_REQ` requesters. It grants requesters in round-robin order and latches the granted 7-bit word. It then sequences a serializer through the frame: start bit, 7 data bits LSB-first, even-parity bit, stop bit. Its frame format and bit timing match the team's UART receiver, so a single receiver on the far end decodes every requester's traffic.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, ≥2.
- `DATA_W`, 7: data bits per frame.
- `CLKS_PER_BIT`, 1736: clock cycles per serial bit (104167 ns / 60 ns clock), ≥2.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  NUM_REQ  request i has a word to send.
- `req_data`  in  NUM_REQ*DATA_W  word for request i, in bits [i*DATA_W +: DATA_W].
- `req_ready`  out  NUM_REQ  one-cycle accept pulse to request i.
- `tx_line`  out  1  serial output; idle high.
- `busy`  out  1  a frame is in progress.
- `grant_id`  out  $clog2(NUM_REQ)  index of the requester owning the current or last frame.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If any `req_valid` is high, select the first valid index searching upward from `last_grant+1`, wrapping modulo NUM_REQ.
  - Assert `req_ready[sel]` for that cycle only.
  - Latch `req_data[sel]`, set `grant_id=sel` and `last_grant=sel`, then go to START.
- START: `tx_line=0` for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - `tx_line=data[bit_idx]`, with bit_idx running 0..6, each bit held CLKS_PER_BIT cycles.
  - After bit 6, go to PARITY.
- PARITY: `tx_line` = XOR of the 7 latched bits, so the total count of ones in data plus parity is even. Held CLKS_PER_BIT cycles.
- STOP: `tx_line=1` for CLKS_PER_BIT cycles, then go to IDLE.
- `busy` is high in every state except IDLE.
- Requester contract:
  - `req_data[i]` must stay stable while `req_valid[i]` is high and `req_ready[i]` has not pulsed.
  - Dropping `req_valid` before accept is legal; nothing is sent for that request.
- `req_valid` is ignored while `busy` is high. No queueing beyond the single latched word.
- Widths:
  - Baud counter is $clog2(CLKS_PER_BIT) bits. It counts 0..CLKS_PER_BIT-1, and the bit advances on terminal count.
  - Bit index is 3 bits.
  - No overflow is possible.
- Reset values: `tx_line=1`, `busy=0`, `req_ready=0`, `grant_id=0`, `last_grant=NUM_REQ-1` (first priority goes to requester 0). Internal counters are 0 and the state is IDLE.
- Reset mid-frame: the frame is abandoned. The next cycle shows the reset values above. No `req_ready` is issued, and arbitration restarts from requester 0.

## Timing
- All outputs are registered.
- Accept cycle T (IDLE, `req_ready` high): `tx_line` falls and `busy` rises at T+1.
- The frame occupies cycles T+1 .. T+10*CLKS_PER_BIT. `busy` falls at T+10*CLKS_PER_BIT+1, which is an IDLE cycle.
- The earliest next accept is in that same IDLE cycle. Back-to-back frame period is 10*CLKS_PER_BIT+1 cycles, with `tx_line=1` during the gap cycle.
- Simultaneous requests resolve in a single cycle, with no extra latency.
- Starvation bound: a continuously valid requester is granted within NUM_REQ frames.

## Structure
- Shared package `uart_pkg` holds:
  - constants `DATA_W=7`, `FRAME_BITS=10`, and the default `CLKS_PER_BIT=1736`;
  - the state enum `uart_tx_state_t`;
  - the even-parity function.
  The receiver imports the same package.
- Sub-module `uart_tx_serializer`:
  - contains the state machine, baud counter and bit index;
  - interface: `load` pulse + 7-bit data in; `tx_line` and `busy` out.
- `uart_tx_arbiter` contains only the round-robin select, the latch and the handshake.

## Test plan
All scenarios use CLKS_PER_BIT=4 and NUM_REQ=4.

1. **Reset:** hold `rst` 3 cycles with random `req_valid` → `tx_line=1`, `busy=0`, `req_ready=0`, `grant_id=0` throughout and on the first cycle after release.
2. **Single frame, parity 0:** `req_valid[0]=1`, data 7'h55 → one-cycle `req_ready[0]`. `tx_line` emits 0,1,0,1,0,1,0,1,0,1, each level 4 cycles (parity 0). `busy` is high for exactly 40 cycles.
3. **Parity 1:** request 2 with data 7'h07 → bits 0,1,1,1,0,0,0,0,1,1, with parity bit 1. `grant_id=2`.
4. **All requesters at once:** all four valid at once and held → grants in order 0,1,2,3. Accept pulses are 41 cycles apart, with exactly one `tx_line=1` gap cycle between frames.
5. **Fairness:** `req_valid[1]` held high; `req_valid[2]` raised during frame 1 → grant sequence 1,2,1,2.
6. **Reset mid-frame:** assert `rst` at cycle 15 of a frame from requester 3 → `tx_line=1` and `busy=0` the next cycle. After release with all requests valid, the first grant is 0.
